load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Accepts one load or store request at a time from the core and drives the word-addressed, byte-masked data memory with its active-low chip-select and active-low write-enable. Aligns store data onto byte lanes, generates the byte mask, and captures read data on the memory's negedge read. Returns sign- or zero-extended load results through a valid/ready response handshake.

## Interface

Parameters:
- none; data and address are fixed at 32 bits.

Ports:
- clk  input  1  single clock; the FSM and all registers update on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are legal for loads only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned address or illegal funct3; no memory access was made.
- mem_addr  output  32  byte address to memory (memory indexes by addr>>2).
- mem_wdata  output  32  lane-replicated store data.
- mem_mask  output  4  byte-lane write mask.
- mem_wr_en  output  1  active-low write enable.
- mem_rd_en  output  1  active-high read enable.
- mem_cs  output  1  active-low chip select.
- mem_rdata  input  32  memory read data, valid after the negedge of the ACCESS cycle.

## Operation

- FSM states are IDLE, ACCESS and RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch the request.
  - Legal and aligned request: go to ACCESS.
  - Otherwise: go to RESP with resp_err=1 and resp_rdata=0.
- Error conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- ACCESS (exactly one cycle):
  - mem_cs=0 and mem_addr=req_addr.
  - Store: mem_wr_en=0, mem_rd_en=0.
  - Load: mem_wr_en=1, mem_rd_en=1, mem_mask=0000.
- Store lane placement:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_mask=0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_mask = addr[1] ? 1100 : 0011.
  - SW: mem_wdata=wdata, mem_mask=1111.
- Load extraction:
  - Shift mem_rdata right by 8*addr[1:0].
  - B/H take bit 7/15 as the sign bit.
  - BU/HU zero-extend.
  - W passes the word unchanged.
- The load result is registered into resp_rdata at the posedge ending ACCESS.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - Leave for IDLE on the posedge where resp_ready=1.
- Idle memory outputs (reset, IDLE and RESP): mem_cs=1, mem_wr_en=1, mem_rd_en=0, mem_mask=0000, mem_addr=0, mem_wdata=0.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, memory outputs at idle values.
- Reset asserted at any point forces IDLE immediately, without waiting for a clock edge.
  - If reset is asserted during ACCESS before the negedge, mem_cs rises and no write occurs.
  - A pending response is dropped.
- Cycle numbering for a legal request:
  - Accepted at posedge 0.
  - ACCESS occupies cycle 0–1; the memory acts at the negedge in between.
  - resp_valid rises at posedge 1.
  - If resp_ready is already high, IDLE is re-entered at posedge 2. Peak rate is one request per 3 cycles.
- Error request: resp_valid rises at the posedge after acceptance, with no ACCESS cycle and mem_cs held at 1 throughout.
- req_ready=0 in ACCESS and RESP. A request is never accepted in the same cycle a response completes.
- mem_rdata is sampled only at the posedge ending ACCESS. Changes at any other time are ignored.

## Test plan

- Word round trip:
  - Stimulus: SW 0xDEADBEEF @0x8, then LW @0x8.
  - Required: one cycle with mem_cs=0, mem_wr_en=0, mask 1111; then resp_rdata=0xDEADBEEF with resp_err=0.
- Byte store lanes:
  - Stimulus: SB wdata 0x123456AB @0x9.
  - Required: mem_wdata=0xABABABAB, mem_mask=0010, mem_addr=0x9; following LW @0x8 has only byte 1 changed.
- Load extension:
  - Stimulus: memory word 0x80FF7F80 @0x4.
  - Required: LB @0x4 → 0xFFFFFF80; LBU @0x4 → 0x00000080; LH @0x6 → 0xFFFF80FF; LHU @0x6 → 0x000080FF.
- Misaligned and illegal requests:
  - Stimulus: LH @0x3, SW @0x2, load funct3 011.
  - Required: each returns resp_err=1 and resp_rdata=0, mem_cs stays 1, response one cycle after acceptance.
- Response backpressure:
  - Stimulus: hold resp_ready=0 for 3 cycles after resp_valid rises.
  - Required: resp_valid and resp_rdata stable and req_ready=0 throughout; IDLE at the posedge where resp_ready=1.
- Reset mid-operation:
  - Stimulus: assert reset during ACCESS of SW 0xFFFFFFFF @0x0, before the negedge.
  - Required: mem_cs=1 immediately, memory word unchanged, resp_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and memory-side port bundle for the LSU.
// Core side is valid/ready in both directions; memory side has no flow control.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface load_store_unit_mem_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic        mem_cs;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en, mem_cs,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en, mem_cs,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: IDLE -> ACCESS -> RESP, 2 cycles to response (1 on error).
// req_ready only in IDLE; the response is held in RESP until resp_ready.
module load_store_unit (
  input  logic                         clk,
  input  logic                         reset,
  load_store_unit_if.slave             core,
  load_store_unit_mem_if.master        mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        mem_cs_q, mem_cs_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  function automatic logic req_error(input logic st, input logic [2:0] f3, input logic [1:0] off);
    logic illegal;
    logic misal;
    if (st) illegal = f3[2] | (f3[1:0] == 2'b11);
    else    illegal = (f3[1:0] == 2'b11) | (f3 == 3'b110);
    misal = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal | misal;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    // memory pins return to idle every cycle unless a new access is launched
    mem_addr_d   = 32'd0;
    mem_wdata_d  = 32'd0;
    mem_mask_d   = 4'b0000;
    mem_wr_en_d  = 1'b1;
    mem_rd_en_d  = 1'b0;
    mem_cs_d     = 1'b1;

    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          is_store_d  = core.req_is_store;
          funct3_d    = core.req_funct3;
          off_d       = core.req_addr[1:0];
          req_ready_d = 1'b0;
          if (req_error(core.req_is_store, core.req_funct3, core.req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d    = ACCESS;
            resp_err_d = 1'b0;
            mem_cs_d   = 1'b0;
            mem_addr_d = core.req_addr;
            if (core.req_is_store) begin
              mem_wr_en_d = 1'b0;
              case (core.req_funct3[1:0])
                2'b00: begin
                  mem_wdata_d = {4{core.req_wdata[7:0]}};
                  mem_mask_d  = 4'b0001 << core.req_addr[1:0];
                end
                2'b01: begin
                  mem_wdata_d = {2{core.req_wdata[15:0]}};
                  mem_mask_d  = core.req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  mem_wdata_d = core.req_wdata;
                  mem_mask_d  = 4'b1111;
                end
              endcase
            end else begin
              mem_rd_en_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = is_store_q ? 32'd0 : load_extract(funct3_q, off_q, mem.mem_rdata);
      end
      RESP: begin
        if (core.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_mask_q   <= 4'b0000;
      mem_wr_en_q  <= 1'b1;
      mem_rd_en_q  <= 1'b0;
      mem_cs_q     <= 1'b1;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_cs_q     <= mem_cs_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign core.req_ready  = req_ready_q;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_err   = resp_err_q;
  assign core.resp_rdata = resp_rdata_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;
  assign mem.mem_mask    = mem_mask_q;
  assign mem.mem_wr_en   = mem_wr_en_q;
  assign mem.mem_rd_en   = mem_rd_en_q;
  assign mem.mem_cs      = mem_cs_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, directed cases then random traffic.
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  load_store_unit_if     core_if ();
  load_store_unit_mem_if mem_if ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .core  (core_if),
    .mem   (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-byte memory acted on by the DUT pins, plus the expected image from request semantics
  logic [31:0] mem_arr [16];
  logic [31:0] ref_mem [16];

  always @(negedge clk) begin
    if (!mem_if.mem_cs) begin
      if (!mem_if.mem_wr_en)
        for (int i = 0; i < 4; i++)
          if (mem_if.mem_mask[i]) mem_arr[mem_if.mem_addr[5:2]][8*i +: 8] = mem_if.mem_wdata[8*i +: 8];
      if (mem_if.mem_rd_en) mem_if.mem_rdata = mem_arr[mem_if.mem_addr[5:2]];
    end else begin
      mem_if.mem_rdata = $urandom;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return ref_mem[a[5:2]][{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
    ref_mem[a[5:2]][{a[1:0], 3'b000} +: 8] = b;
  endtask

  // Assumes entry at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    int          size;
    bit          err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_mask;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (st) err = (f3 > 3'd2);
    else    err = (f3 == 3'd3) || (f3 >= 3'd6);
    if (!err && (int'(addr[1:0]) % size) != 0) err = 1'b1;
    exp_rd = 32'd0;
    if (!err && !st) begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(rd_byte(addr + 32'(k))) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      exp_rd = v;
    end
    exp_wd   = 32'd0;
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp_wd[8*i +: 8] = wd[8*(i % size) +: 8];
      if (i >= int'(addr[1:0]) && i < int'(addr[1:0]) + size) exp_mask[i] = 1'b1;
    end
    if (st && !err)
      for (int k = 0; k < size; k++) wr_byte(addr + 32'(k), wd[8*k +: 8]);

    chk("req_ready_idle", core_if.req_ready, 1);
    core_if.req_valid    = 1'b1;
    core_if.req_is_store = st;
    core_if.req_funct3   = f3;
    core_if.req_addr     = addr;
    core_if.req_wdata    = wd;
    @(posedge clk); #1;
    core_if.req_valid = 1'b0;
    core_if.req_addr  = $urandom;
    core_if.req_wdata = $urandom;
    if (!err) begin
      chk("access_cs", mem_if.mem_cs, 0);
      chk("access_addr", mem_if.mem_addr, addr);
      chk("access_wr_en", mem_if.mem_wr_en, st ? 0 : 1);
      chk("access_rd_en", mem_if.mem_rd_en, st ? 0 : 1);
      chk("access_mask", mem_if.mem_mask, st ? exp_mask : 4'b0000);
      if (st) chk("access_wdata", mem_if.mem_wdata, exp_wd);
      chk("access_resp_valid", core_if.resp_valid, 0);
      chk("access_req_ready", core_if.req_ready, 0);
      @(posedge clk); #1;
    end
    chk("resp_valid", core_if.resp_valid, 1);
    chk("resp_err", core_if.resp_err, err);
    chk("resp_rdata", core_if.resp_rdata, exp_rd);
    chk("resp_mem_cs", mem_if.mem_cs, 1);
    chk("resp_req_ready", core_if.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_resp_valid", core_if.resp_valid, 1);
      chk("hold_resp_rdata", core_if.resp_rdata, exp_rd);
      chk("hold_resp_err", core_if.resp_err, err);
      chk("hold_req_ready", core_if.req_ready, 0);
    end
    core_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    core_if.resp_ready = 1'b0;
    chk("done_resp_valid", core_if.resp_valid, 0);
    chk("done_req_ready", core_if.req_ready, 1);
    chk("done_mem_cs", mem_if.mem_cs, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    reset                = 1'b0;
    core_if.req_valid    = 1'b0;
    core_if.req_is_store = 1'b0;
    core_if.req_funct3   = 3'd0;
    core_if.req_addr     = 32'd0;
    core_if.req_wdata    = 32'd0;
    core_if.resp_ready   = 1'b0;
    #12;
    chk("rst_req_ready", core_if.req_ready, 1);
    chk("rst_resp_valid", core_if.resp_valid, 0);
    chk("rst_resp_rdata", core_if.resp_rdata, 0);
    chk("rst_resp_err", core_if.resp_err, 0);
    chk("rst_mem_cs", mem_if.mem_cs, 1);
    chk("rst_mem_wr_en", mem_if.mem_wr_en, 1);
    chk("rst_mem_rd_en", mem_if.mem_rd_en, 0);
    chk("rst_mem_mask", mem_if.mem_mask, 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // word round trip
    do_req(1, 3'b010, 32'h8, 32'hDEADBEEF, 0);
    do_req(0, 3'b010, 32'h8, 32'h0, 0);
    chk("lw_roundtrip", core_if.resp_rdata, 32'hDEADBEEF);

    // byte store lanes: only byte 1 of word 0x8 changes
    do_req(1, 3'b000, 32'h9, 32'h123456AB, 0);
    do_req(0, 3'b010, 32'h8, 32'h0, 0);
    chk("sb_lane_word", core_if.resp_rdata, 32'hDEADABEF);

    // load extension
    do_req(1, 3'b010, 32'h4, 32'h80FF7F80, 0);
    do_req(0, 3'b000, 32'h4, 32'h0, 0);
    chk("lb_sext", core_if.resp_rdata, 32'hFFFFFF80);
    do_req(0, 3'b100, 32'h4, 32'h0, 0);
    chk("lbu_zext", core_if.resp_rdata, 32'h00000080);
    do_req(0, 3'b001, 32'h6, 32'h0, 0);
    chk("lh_sext", core_if.resp_rdata, 32'hFFFF80FF);
    do_req(0, 3'b101, 32'h6, 32'h0, 0);
    chk("lhu_zext", core_if.resp_rdata, 32'h000080FF);

    // misaligned and illegal
    do_req(0, 3'b001, 32'h3, 32'h0, 0);
    do_req(1, 3'b010, 32'h2, 32'h55555555, 0);
    do_req(0, 3'b011, 32'h0, 32'h0, 0);
    do_req(1, 3'b100, 32'h0, 32'h11111111, 0);
    do_req(0, 3'b110, 32'h10, 32'h0, 1);

    // response backpressure
    do_req(0, 3'b010, 32'h4, 32'h0, 3);
    do_req(1, 3'b001, 32'h22, 32'hCAFE1234, 3);

    // reset during ACCESS of a store, before the memory negedge
    core_if.req_valid    = 1'b1;
    core_if.req_is_store = 1'b1;
    core_if.req_funct3   = 3'b010;
    core_if.req_addr     = 32'h0;
    core_if.req_wdata    = 32'hFFFFFFFF;
    @(posedge clk); #1;
    core_if.req_valid = 1'b0;
    chk("rstmid_access_cs", mem_if.mem_cs, 0);
    reset = 1'b0;
    #1;
    chk("rstmid_cs_immediate", mem_if.mem_cs, 1);
    chk("rstmid_wr_en_immediate", mem_if.mem_wr_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_resp_valid", core_if.resp_valid, 0);
    chk("rstmid_req_ready", core_if.req_ready, 1);
    chk("rstmid_mem_word", mem_arr[0], ref_mem[0]);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'($urandom_range(0, 3)));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), mem_arr[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
